// File: rtl/rand_index_gen_multi.sv
// rand_index_gen_multi: multi-lane seedable LCG index generator emitting bursts of index vectors on valid/ready
module rand_index_gen_multi #(
    parameter int RANGE     = 64,
    parameter int CHANNELS  = 4,
    parameter int MULT      = 5,
    parameter int INC       = 1,
    parameter int SEGMENTED = 1,
    parameter int CNT_W     = 16,
    localparam int W  = $clog2(RANGE),
    localparam int OW = SEGMENTED != 0 ? $clog2(RANGE * CHANNELS) : W
) (
    input  logic                   clk,
    input  logic                   arst_n_in,
    input  logic                   seed_load_in,
    input  logic [CHANNELS*W-1:0]  seed_in,
    input  logic                   start_in,
    input  logic [CNT_W-1:0]       burst_len_in,
    output logic                   busy_out,
    output logic                   idx_valid_out,
    input  logic                   idx_ready_in,
    output logic [CHANNELS*OW-1:0] idx_out,
    output logic                   done_out
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic [CNT_W-1:0] remaining;
    logic [W-1:0] cur [CHANNELS];
    logic [W-1:0] nxt [CHANNELS];
    logic hs, idle_seed, idle_start;
    if ((RANGE & (RANGE - 1)) != 0 || RANGE < 4 || MULT % 4 != 1 || INC % 2 == 0) begin : g_bad_params
        $error("rand_index_gen_multi: RANGE must be a power of two >= 4, MULT mod 4 == 1, INC odd");
    end
    function automatic logic [W-1:0] f(input logic [W-1:0] x);
        return W'(MULT * int'(x) + INC);
    endfunction
    assign idx_valid_out = state == RUN;
    assign busy_out      = state != IDLE;
    assign done_out      = state == DONE;
    assign hs            = idx_valid_out && idx_ready_in;
    assign idle_seed     = state == IDLE && seed_load_in;
    assign idle_start    = state == IDLE && start_in;
    always_comb begin
        state_nxt = state == IDLE ? (start_in ? (burst_len_in != '0 ? RUN : DONE) : IDLE) :
                    state == RUN  ? (hs && remaining == CNT_W'(1) ? DONE : RUN) : IDLE;
    end
    // nxt holds f(cur) so every handshake can advance without a combinational LCG in the output path
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state     <= IDLE;
            remaining <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                cur[c] <= W'(RANGE - 2 - c);
                nxt[c] <= f(W'(RANGE - 2 - c));
            end
        end else begin
            state <= state_nxt;
            if (idle_start) remaining <= burst_len_in;
            else if (hs) remaining <= remaining - 1'b1;
            for (int c = 0; c < CHANNELS; c++) begin
                if (idle_seed) begin
                    cur[c] <= seed_in[c*W +: W];
                    nxt[c] <= f(seed_in[c*W +: W]);
                end else if (hs) begin
                    cur[c] <= nxt[c];
                    nxt[c] <= f(nxt[c]);
                end
            end
        end
    end
    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        assign idx_out[g*OW +: OW] = OW'(SEGMENTED != 0 ? g * RANGE + int'(cur[g]) : int'(cur[g]));
    end
endmodule

// File: tb/tb_rand_index_gen_multi.sv
// tb_rand_index_gen_multi: vector table, corner-case sequences and randomized bursts against an arithmetic lane model
module tb_rand_index_gen_multi;
    localparam int RANGE = 64, CH = 4, MULT = 5, INC = 1, W = 6, OW = 8;
    logic clk = 0, arst_n_in = 0, seed_load_in = 0, start_in = 0, idx_ready_in = 0;
    logic [CH*W-1:0] seed_in = '0;
    logic [15:0] burst_len_in = '0;
    logic busy_out, idx_valid_out, done_out;
    logic [CH*OW-1:0] idx_out;
    int total = 0, passed = 0;
    int m_x [CH];
    logic [31:0] vecs [80];

    rand_index_gen_multi #(.RANGE(RANGE), .CHANNELS(CH), .MULT(MULT), .INC(INC), .SEGMENTED(1), .CNT_W(16)) dut (
        .clk(clk), .arst_n_in(arst_n_in), .seed_load_in(seed_load_in), .seed_in(seed_in),
        .start_in(start_in), .burst_len_in(burst_len_in), .busy_out(busy_out),
        .idx_valid_out(idx_valid_out), .idx_ready_in(idx_ready_in), .idx_out(idx_out), .done_out(done_out));

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic [23:0] sd;
        int          len;
        logic [31:0] f;
        logic [31:0] l;
    } vec_t;
    vec_t tbl [6];

    function automatic logic [31:0] pk(int a, int b, int c, int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction
    function automatic logic [23:0] sp(int a, int b, int c, int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction
    function automatic logic [31:0] mvec();
        logic [31:0] r;
        for (int c = 0; c < CH; c++) r[c*8 +: 8] = 8'(c * RANGE + m_x[c]);
        return r;
    endfunction
    task automatic madv();
        for (int c = 0; c < CH; c++) m_x[c] = (MULT * m_x[c] + INC) % RANGE;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask
    task automatic do_reset();
        @(negedge clk);
        arst_n_in = 0; start_in = 0; seed_load_in = 0; idx_ready_in = 0;
        @(negedge clk);
        @(negedge clk);
        arst_n_in = 1;
        for (int c = 0; c < CH; c++) m_x[c] = RANGE - 2 - c;
    endtask
    task automatic run_burst(input logic ld, input logic [23:0] sd, input int len, output int hs, output bit done_ok);
        seed_load_in = ld; seed_in = sd; start_in = 1; burst_len_in = 16'(len); idx_ready_in = 1;
        @(negedge clk);
        start_in = 0; seed_load_in = 0;
        hs = 0; done_ok = 0;
        for (int i = 0; i < len + 10 && !done_ok; i++) begin
            if (done_out) done_ok = 1;
            else begin
                if (idx_valid_out && hs < 80) vecs[hs] = idx_out;
                if (idx_valid_out) hs++;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int hs, cnt, rem, cyc, len;
        bit done_ok, saw_done;
        bit seen [RANGE];
        logic [31:0] hold;
        logic ld;
        logic [23:0] sd;
        tbl[0] = '{1'b0, 24'd0, 2, pk(62, 125, 188, 251), pk(55, 114, 173, 232)};
        tbl[1] = '{1'b1, sp(0, 0, 0, 0), 5, pk(0, 64, 128, 192), pk(28, 92, 156, 220)};
        tbl[2] = '{1'b1, sp(0, 1, 2, 3), 1, pk(0, 65, 130, 195), pk(0, 65, 130, 195)};
        tbl[3] = '{1'b1, sp(63, 63, 63, 63), 2, pk(63, 127, 191, 255), pk(60, 124, 188, 252)};
        tbl[4] = '{1'b0, 24'd0, 0, 32'd0, 32'd0};
        tbl[5] = '{1'b0, 24'd0, 1, pk(45, 109, 173, 237), pk(45, 109, 173, 237)};

        do_reset();
        chk("rst_valid", 32'(idx_valid_out), 32'd0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_done", 32'(done_out), 32'd0);
        chk("rst_idx", idx_out, pk(62, 125, 188, 251));

        for (int t = 0; t < 6; t++) begin
            run_burst(tbl[t].ld, tbl[t].sd, tbl[t].len, hs, done_ok);
            chk($sformatf("tbl%0d_hs", t), 32'(hs), 32'(tbl[t].len));
            chk($sformatf("tbl%0d_done", t), 32'(done_ok), 32'd1);
            chk($sformatf("tbl%0d_done_valid", t), 32'(idx_valid_out), 32'd0);
            if (tbl[t].len > 0) begin
                chk($sformatf("tbl%0d_first", t), vecs[0], tbl[t].f);
                chk($sformatf("tbl%0d_last", t), vecs[tbl[t].len - 1], tbl[t].l);
            end
            @(negedge clk);
            chk($sformatf("tbl%0d_idle_busy", t), 32'(busy_out), 32'd0);
        end

        do_reset();
        run_burst(1'b0, 24'd0, 65, hs, done_ok);
        chk("period_hs", 32'(hs), 32'd65);
        chk("period_done", 32'(done_ok), 32'd1);
        foreach (seen[i]) seen[i] = 0;
        for (int i = 0; i < 64; i++) seen[vecs[i][5:0]] = 1;
        cnt = 0;
        foreach (seen[i]) cnt += int'(seen[i]);
        chk("period_unique", 32'(cnt), 32'd64);
        chk("period_wrap", vecs[64], vecs[0]);
        @(negedge clk);

        do_reset();
        start_in = 1; burst_len_in = 16'd3; idx_ready_in = 0;
        @(negedge clk);
        start_in = 0;
        hold = idx_out;
        chk("stall_first", hold, pk(62, 125, 188, 251));
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(idx_valid_out), 32'd1);
            chk("stall_hold", idx_out, hold);
            start_in = i == 2; burst_len_in = 16'd10;
            @(negedge clk);
        end
        start_in = 0; idx_ready_in = 1; hs = 0; saw_done = 0;
        for (int i = 0; i < 20 && !saw_done; i++) begin
            if (done_out) saw_done = 1;
            else begin
                if (idx_valid_out) hs++;
                @(negedge clk);
            end
        end
        chk("stall_hs", 32'(hs), 32'd3);
        chk("stall_done", 32'(saw_done), 32'd1);
        @(negedge clk);
        chk("stall_idle", 32'(busy_out | idx_valid_out), 32'd0);
        @(negedge clk);
        chk("stall_no_extend", 32'(busy_out | idx_valid_out), 32'd0);

        start_in = 1; burst_len_in = 16'd0;
        @(negedge clk);
        start_in = 0;
        chk("len0_done", 32'(done_out), 32'd1);
        chk("len0_valid", 32'(idx_valid_out), 32'd0);
        @(negedge clk);
        chk("len0_idle", 32'(busy_out | idx_valid_out | done_out), 32'd0);

        do_reset();
        start_in = 1; burst_len_in = 16'd10; idx_ready_in = 1;
        @(negedge clk);
        start_in = 0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_valid_before", 32'(idx_valid_out), 32'd1);
        #2 arst_n_in = 0;
        #1;
        chk("mid_valid_async", 32'(idx_valid_out), 32'd0);
        chk("mid_busy_async", 32'(busy_out), 32'd0);
        chk("mid_idx_reset", idx_out, pk(62, 125, 188, 251));
        saw_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) arst_n_in = 1;
            saw_done |= done_out | busy_out;
        end
        chk("mid_no_done", 32'(saw_done), 32'd0);

        do_reset();
        for (int b = 0; b < 30; b++) begin
            ld = 1'($urandom_range(0, 1)); sd = 24'($urandom); len = $urandom_range(0, 8);
            seed_load_in = ld; seed_in = sd; start_in = 1; burst_len_in = 16'(len);
            if (ld) for (int c = 0; c < CH; c++) m_x[c] = int'(sd[c*W +: W]);
            @(negedge clk);
            start_in = 0; seed_load_in = 0; rem = len; cyc = 0;
            while (rem > 0 && cyc < 100) begin
                chk("rnd_valid", 32'(idx_valid_out), 32'd1);
                chk("rnd_idx", idx_out, mvec());
                idx_ready_in = 1'($urandom_range(0, 1));
                start_in = 1'($urandom_range(0, 1));
                seed_load_in = 1'($urandom_range(0, 1));
                seed_in = 24'($urandom);
                burst_len_in = 16'($urandom_range(1, 9));
                @(negedge clk);
                if (idx_ready_in) begin
                    madv();
                    rem--;
                end
                cyc++;
            end
            start_in = 0; seed_load_in = 0;
            chk("rnd_timeout", 32'(rem), 32'd0);
            chk("rnd_done", 32'(done_out), 32'd1);
            chk("rnd_done_valid", 32'(idx_valid_out), 32'd0);
            @(negedge clk);
            chk("rnd_idle", 32'(busy_out), 32'd0);
            chk("rnd_idle_idx", idx_out, mvec());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rand_index_gen_multi.md
Name: rand_index_gen_multi

Overview:
- Multi-channel, seedable pseudo-random index generator for sparse binary HDC vector construction.
- Each of CHANNELS lanes runs an independent LCG, x' = (MULT*x + INC) mod RANGE.
- Emits bursts of index vectors on a valid/ready stream, one vector per accepted beat.
- Optional segmented mode maps lane c into its own segment, so the indices in one vector are always distinct positions of a RANGE*CHANNELS-wide hypervector.

Parameters:
- RANGE, 64: per-lane index range; power of two, >= 4; W = clog2(RANGE).
- CHANNELS, 4: number of lanes (indices per vector).
- MULT, 5: LCG multiplier; must satisfy MULT mod 4 == 1.
- INC, 1: LCG increment; must be odd.
- SEGMENTED, 1: 1 gives global index c*RANGE + x; 0 gives raw x.
- CNT_W, 16: width of the burst length.
- Elaboration error if RANGE is not a power of two, MULT mod 4 != 1, or INC is even.

Ports:
- clk  in  1  clock.
- arst_n_in  in  1  asynchronous active-low reset.
- seed_load_in  in  1  load seeds; honoured only in IDLE.
- seed_in  in  CHANNELS*W  lane c seed in bits [c*W +: W].
- start_in  in  1  start a burst; honoured only in IDLE.
- burst_len_in  in  CNT_W  number of vectors in the burst.
- busy_out  out  1  high in RUN and DONE.
- idx_valid_out  out  1  vector available.
- idx_ready_in  in  1  consumer accepts.
- idx_out  out  CHANNELS*OW  lane c in bits [c*OW +: OW]; OW = clog2(RANGE*CHANNELS) if SEGMENTED, else W.
- done_out  out  1  one-cycle pulse at burst end.

Behaviour:
- f(x) = low W bits of (MULT*x + INC). The parameter rules give the full period RANGE per lane.
- Per-lane registers: cur_c (presented value) and nxt_c = f(cur_c) (precomputed), so throughput is one vector per cycle.
- Reset (async, immediate):
  - cur_c = (RANGE-2-c) mod RANGE; nxt_c = f(cur_c).
  - FSM = IDLE; remaining = 0.
  - idx_valid_out, busy_out, done_out = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - seed_load_in=1: next cycle cur_c <= seed_c and nxt_c <= f(seed_c).
  - start_in=1 with burst_len_in > 0: remaining <= burst_len_in; go to RUN.
  - start_in=1 with burst_len_in == 0: go to DONE; no vector is emitted.
  - Simultaneous seed_load_in and start_in: both take effect; the first vector uses the new seeds.
- RUN:
  - idx_valid_out = 1.
  - Handshake (valid && ready): cur_c <= nxt_c, nxt_c <= f(nxt_c), remaining <= remaining-1.
  - Handshake when remaining == 1: go to DONE.
  - No handshake: idx_out and remaining hold.
  - start_in and seed_load_in are ignored.
- DONE: exactly one cycle; done_out = 1, idx_valid_out = 0; go to IDLE. start_in is ignored in DONE.
- idx_valid_out is registered; the first vector is valid the cycle after start is accepted (latency 1).
- Lane state persists across bursts; a new burst continues each sequence where the last stopped.
- Output mapping:
  - SEGMENTED=1: lane field = c*RANGE + cur_c, zero-extended to OW.
  - SEGMENTED=0: lane field = cur_c.
- Wrap-around: arithmetic is modulo RANGE; there is no overflow flag.
- Reset mid-burst: outputs drop to reset values immediately; the pending burst is discarded and no done_out is issued.

Test Plan:
- Reset, then start with len=2, ready=1 (RANGE=64, MULT=5, INC=1, CHANNELS=4, SEGMENTED=1):
  - vector 1 = {62, 125, 188, 251};
  - vector 2 = {55, 114, 173, 232};
  - done_out pulses the cycle after vector 2; busy_out = 0 the cycle after that.
- Seed load 0,0,0,0 in IDLE, then start len=5: lane 0 raw values 0, 1, 6, 31, 28; lane 3 field = 192 + the same sequence.
- Start len=65 after reset: lane 0 covers all 64 values exactly once in vectors 1-64; vector 65 equals vector 1.
- Start len=3, hold ready low 5 cycles after the first valid:
  - idx_out stable and valid high throughout;
  - exactly 3 handshakes, then done_out.
- Start with len=0: done_out one cycle later; idx_valid_out never asserts. A start_in pulse during RUN does not extend the burst.
- Assert arst_n_in low mid-burst: idx_valid_out drops asynchronously; cur_c returns to 62, 61, 60, 59; no done_out.
